// File: rtl/bsg_vanilla_pkg.sv
// Shared vanilla-core definitions used by the integer divider.
package bsg_vanilla_pkg;

    typedef enum logic [1:0] {
        eDIV  = 2'd0,
        eDIVU = 2'd1,
        eREM  = 2'd2,
        eREMU = 2'd3
    } idiv_op_e;

endpackage

// File: rtl/vanilla_idiv_iterative.sv
// Iterative restoring integer divider (RV32M DIV/DIVU/REM/REMU).
// One width_p+1-bit subtractor is time-shared: dividend negation on the
// accept edge, divisor negation in PREP, shift-subtract in CALC and the
// final sign correction in FIX. Divide-by-zero and signed overflow
// leave PREP straight for DONE.
module vanilla_idiv_iterative
    import bsg_vanilla_pkg::*;
#(
    parameter int width_p     = 32,
    parameter int tag_width_p = 5
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   v_i,
    output logic                   ready_o,
    input  idiv_op_e               op_i,
    input  logic [width_p-1:0]     dividend_i,
    input  logic [width_p-1:0]     divisor_i,
    input  logic [tag_width_p-1:0] tag_i,
    input  logic                   flush_i,
    output logic                   v_o,
    output logic [width_p-1:0]     result_o,
    output logic [tag_width_p-1:0] tag_o,
    input  logic                   yumi_i
);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_e;

    localparam int CNT_W = $clog2(width_p + 1);
    localparam logic [width_p-1:0] MIN_C = {1'b1, {(width_p-1){1'b0}}};

    state_e                 state_q, state_d;
    idiv_op_e               op_q;
    logic [tag_width_p-1:0] tag_q;
    logic [width_p-1:0]     rem_q;      // raw dividend until PREP, then partial remainder
    logic [width_p-1:0]     quo_q;      // |dividend| shifting out, quotient shifting in
    logic [width_p-1:0]     dsr_q;      // raw divisor until PREP, then |divisor|
    logic [width_p-1:0]     result_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   neg_quo_q, neg_rem_q;

    logic               accept;
    logic               sgn_i, sgn_q, is_rem_q;
    logic               dvd_neg, dsr_neg, div0, ovf, special;
    logic [width_p-1:0] special_res, fix_sel;
    logic               fix_neg;
    logic [width_p:0]   rem_shift, sub_a, sub_b, sub_y;

    assign accept   = v_i & (state_q == IDLE) & ~flush_i;
    assign sgn_i    = (op_i == eDIV) | (op_i == eREM);
    assign sgn_q    = (op_q == eDIV) | (op_q == eREM);
    assign is_rem_q = (op_q == eREM) | (op_q == eREMU);

    // Operand signs and early-out detection, evaluated while in PREP.
    assign dvd_neg  = sgn_q & rem_q[width_p-1];
    assign dsr_neg  = sgn_q & dsr_q[width_p-1];
    assign div0     = (dsr_q == '0);
    assign ovf      = sgn_q & (rem_q == MIN_C) & (&dsr_q);
    assign special  = div0 | ovf;
    // div0: DIV -> all ones, REM -> dividend; overflow: DIV -> dividend, REM -> 0
    assign special_res = div0 ? (is_rem_q ? rem_q : '1)
                              : (is_rem_q ? '0 : rem_q);

    assign rem_shift = {rem_q, quo_q[width_p-1]};
    assign fix_sel   = is_rem_q ? rem_q : quo_q;
    assign fix_neg   = is_rem_q ? neg_rem_q : neg_quo_q;

    // Operand select for the shared subtractor.
    always_comb begin
        sub_a = '0;
        sub_b = '0;
        case (state_q)
            IDLE:    sub_b = {1'b0, dividend_i};
            PREP:    sub_b = {1'b0, dsr_q};
            CALC:    begin sub_a = rem_shift; sub_b = {1'b0, dsr_q}; end
            FIX:     sub_b = {1'b0, fix_sel};
            default: ;
        endcase
    end

    assign sub_y = sub_a - sub_b;

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; flush aborts from any state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = PREP;
            PREP:    state_d = special ? DONE : CALC;
            CALC:    if (cnt_q == CNT_W'(1)) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    if (yumi_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    // Handshake outputs decoded from state.
    always_comb begin
        ready_o = (state_q == IDLE);
        v_o     = (state_q == DONE);
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            op_q      <= eDIV;
            tag_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    op_q  <= op_i;
                    tag_q <= tag_i;
                    rem_q <= dividend_i;
                    quo_q <= (sgn_i & dividend_i[width_p-1]) ? sub_y[width_p-1:0] : dividend_i;
                    dsr_q <= divisor_i;
                end
                PREP: begin
                    if (dsr_neg) dsr_q <= sub_y[width_p-1:0];
                    neg_rem_q <= dvd_neg;
                    neg_quo_q <= dvd_neg ^ dsr_neg;
                    cnt_q     <= CNT_W'(width_p);
                    rem_q     <= '0;
                    if (special) result_q <= special_res;
                end
                CALC: begin
                    // sub_y MSB set means the trial subtraction went negative: restore
                    rem_q <= sub_y[width_p] ? rem_shift[width_p-1:0] : sub_y[width_p-1:0];
                    quo_q <= {quo_q[width_p-2:0], ~sub_y[width_p]};
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                FIX: result_q <= fix_neg ? sub_y[width_p-1:0] : fix_sel;
                default: ;
            endcase
        end
    end

    assign result_o = result_q;
    assign tag_o    = tag_q;

endmodule

// File: tb/tb_vanilla_idiv_iterative.sv
// Directed bench for vanilla_idiv_iterative at width 32 and width 8.
// Latency is reported as edges-after-accept + 1 (accept edge is edge 0).
module tb_vanilla_idiv_iterative;
    import bsg_vanilla_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        v_i, ready_o, flush_i, v_o, yumi_i;
    idiv_op_e    op_i;
    logic [31:0] dividend_i, divisor_i, result_o;
    logic [4:0]  tag_i, tag_o;

    logic        v8_i, ready8_o, flush8_i, v8_o, yumi8_i;
    idiv_op_e    op8_i;
    logic [7:0]  dividend8_i, divisor8_i, result8_o;
    logic [4:0]  tag8_i, tag8_o;

    vanilla_idiv_iterative #(.width_p(32), .tag_width_p(5)) dut (
        .clk_i(clk), .reset_i(reset), .v_i(v_i), .ready_o(ready_o), .op_i(op_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .tag_i(tag_i),
        .flush_i(flush_i), .v_o(v_o), .result_o(result_o), .tag_o(tag_o), .yumi_i(yumi_i)
    );

    vanilla_idiv_iterative #(.width_p(8), .tag_width_p(5)) dut8 (
        .clk_i(clk), .reset_i(reset), .v_i(v8_i), .ready_o(ready8_o), .op_i(op8_i),
        .dividend_i(dividend8_i), .divisor_i(divisor8_i), .tag_i(tag8_i),
        .flush_i(flush8_i), .v_o(v8_o), .result_o(result8_o), .tag_o(tag8_o), .yumi_i(yumi8_i)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        idiv_op_e    op;
        logic [31:0] a, b;
        logic [4:0]  tag;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    // mode: 0 consume with yumi, 1 flush in DONE, 2 yumi and flush together
    task automatic run32(input string nm, input idiv_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t, input logic [31:0] exp,
                         input int lat, input int hold, input int mode);
        int n;
        @(negedge clk);
        v_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; tag_i = t;
        @(posedge clk);
        @(negedge clk);
        v_i = 1'b0;
        n = 0;
        while (!v_o && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, 64'(n + 1), 64'(lat));
        chk({nm, " result"}, 64'(result_o), 64'(exp));
        chk({nm, " tag"}, 64'(tag_o), 64'(t));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, " hold v_o"}, 64'(v_o), 64'd1);
            chk({nm, " hold ready"}, 64'(ready_o), 64'd0);
            chk({nm, " hold result"}, 64'(result_o), 64'(exp));
            chk({nm, " hold tag"}, 64'(tag_o), 64'(t));
        end
        yumi_i  = (mode != 1);
        flush_i = (mode != 0);
        @(negedge clk);
        yumi_i = 1'b0; flush_i = 1'b0;
        chk({nm, " ready after"}, 64'(ready_o), 64'd1);
        chk({nm, " v_o after"}, 64'(v_o), 64'd0);
    endtask

    task automatic run8(input string nm, input idiv_op_e op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp, input int lat);
        int n;
        @(negedge clk);
        v8_i = 1'b1; op8_i = op; dividend8_i = a; divisor8_i = b; tag8_i = 5'h0C;
        @(posedge clk);
        @(negedge clk);
        v8_i = 1'b0;
        n = 0;
        while (!v8_o && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, 64'(n + 1), 64'(lat));
        chk({nm, " result"}, 64'(result8_o), 64'(exp));
        chk({nm, " tag"}, 64'(tag8_o), 64'h0C);
        yumi8_i = 1'b1;
        @(negedge clk);
        yumi8_i = 1'b0;
    endtask

    vec_t vecs[$];
    int   seen;

    initial begin
        v_i = 0; op_i = eDIV; dividend_i = 0; divisor_i = 0; tag_i = 0; flush_i = 0; yumi_i = 0;
        v8_i = 0; op8_i = eDIV; dividend8_i = 0; divisor8_i = 0; tag8_i = 0; flush8_i = 0; yumi8_i = 0;

        vecs.push_back('{eDIV,  32'hFFFFFFF9, 32'h00000002, 5'h01, 32'hFFFFFFFD, 35});
        vecs.push_back('{eREM,  32'hFFFFFFF9, 32'h00000002, 5'h02, 32'hFFFFFFFF, 35});
        vecs.push_back('{eDIVU, 32'hFFFFFFFF, 32'h00000001, 5'h03, 32'hFFFFFFFF, 35});
        vecs.push_back('{eREMU, 32'd100,      32'd7,        5'h1A, 32'd2,        35});
        vecs.push_back('{eDIV,  32'd5,        32'd0,        5'h04, 32'hFFFFFFFF, 2});
        vecs.push_back('{eREMU, 32'd5,        32'd0,        5'h05, 32'd5,        2});
        vecs.push_back('{eREM,  32'h80000000, 32'hFFFFFFFF, 5'h06, 32'h00000000, 2});
        vecs.push_back('{eDIV,  32'h80000000, 32'hFFFFFFFF, 5'h07, 32'h80000000, 2});
        vecs.push_back('{eREM,  32'hFFFFFFF9, 32'h00000000, 5'h08, 32'hFFFFFFF9, 2});
        vecs.push_back('{eDIV,  32'd7,        32'hFFFFFFFE, 5'h09, 32'hFFFFFFFD, 35});
        vecs.push_back('{eREM,  32'd7,        32'hFFFFFFFE, 5'h0A, 32'd1,        35});
        vecs.push_back('{eDIV,  32'hFFFFFFF9, 32'hFFFFFFFE, 5'h0B, 32'd3,        35});
        vecs.push_back('{eREM,  32'hFFFFFFF9, 32'hFFFFFFFE, 5'h0C, 32'hFFFFFFFF, 35});
        vecs.push_back('{eDIVU, 32'h80000000, 32'hFFFFFFFF, 5'h0D, 32'd0,        35});
        vecs.push_back('{eREMU, 32'h80000000, 32'hFFFFFFFF, 5'h0E, 32'h80000000, 35});
        vecs.push_back('{eDIV,  32'h80000000, 32'd1,        5'h0F, 32'h80000000, 35});
        vecs.push_back('{eDIVU, 32'h12345678, 32'h00000100, 5'h10, 32'h00123456, 35});
        vecs.push_back('{eREM,  32'h12345678, 32'h00000100, 5'h11, 32'h00000078, 35});

        // Reset with request/flush/yumi all asserted: reset must win.
        reset = 1'b1; v_i = 1'b1; yumi_i = 1'b1; flush_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset ready", 64'(ready_o), 64'd1);
        chk("reset v_o", 64'(v_o), 64'd0);
        chk("reset result", 64'(result_o), 64'd0);
        chk("reset tag", 64'(tag_o), 64'd0);
        chk("reset v8_o", 64'(v8_o), 64'd0);
        reset = 1'b0; v_i = 1'b0; yumi_i = 1'b0; flush_i = 1'b0;

        foreach (vecs[i])
            run32($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].tag, vecs[i].exp, vecs[i].lat, 0, 0);

        // Backpressure: result and tag held for 5 cycles.
        run32("bp", eREMU, 32'd100, 32'd7, 5'h1A, 32'd2, 35, 5, 0);
        // Flush while DONE, and yumi+flush together.
        run32("flush_done", eDIVU, 32'd50, 32'd5, 5'h12, 32'd10, 35, 0, 1);
        run32("yumi_flush", eDIV, 32'd5, 32'd0, 5'h13, 32'hFFFFFFFF, 2, 0, 2);

        // Flush in IDLE beats a valid request.
        @(negedge clk);
        v_i = 1'b1; flush_i = 1'b1; op_i = eDIVU; dividend_i = 32'd9; divisor_i = 32'd3;
        @(negedge clk);
        v_i = 1'b0; flush_i = 1'b0;
        chk("idle flush ready", 64'(ready_o), 64'd1);

        // Flush at cycle 10 of a running division.
        @(negedge clk);
        v_i = 1'b1; op_i = eDIVU; dividend_i = 32'd1000; divisor_i = 32'd3; tag_i = 5'h14;
        @(posedge clk);
        @(negedge clk);
        v_i = 1'b0;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("midflush ready", 64'(ready_o), 64'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (v_o) seen = 1;
        end
        chk("midflush no v_o", 64'(seen), 64'd0);
        run32("after flush", eDIVU, 32'd81, 32'd9, 5'h15, 32'd9, 35, 0, 0);

        // Reset pulse during CALC drops the operation.
        @(negedge clk);
        v_i = 1'b1; op_i = eDIV; dividend_i = 32'hFFFFFFF9; divisor_i = 32'd2; tag_i = 5'h16;
        @(posedge clk);
        @(negedge clk);
        v_i = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset ready", 64'(ready_o), 64'd1);
        chk("midreset result", 64'(result_o), 64'd0);
        chk("midreset tag", 64'(tag_o), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (v_o) seen = 1;
        end
        chk("midreset no v_o", 64'(seen), 64'd0);
        run32("after reset", eREM, 32'hFFFFFFF9, 32'd2, 5'h17, 32'hFFFFFFFF, 35, 0, 0);

        // Narrow instance: width 8 completes at cycle 11.
        run8("w8 div", eDIV, 8'hF9, 8'h02, 8'hFD, 11);
        run8("w8 rem", eREM, 8'hF9, 8'h02, 8'hFF, 11);
        run8("w8 ovf", eDIV, 8'h80, 8'hFF, 8'h80, 2);
        run8("w8 remu", eREMU, 8'd100, 8'd7, 8'd2, 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vanilla_idiv_iterative.md
VANILLA_IDIV_ITERATIVE -- requirements
Module: vanilla_idiv_iterative

Interface
REQ-001 Parameter width_p, default 32: operand/result width in bits; legal range 2 and up.
REQ-002 Parameter tag_width_p, default 5: width of the passthrough destination tag (RV32 register address).
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_i  input  1  reset, synchronous and active-high.
REQ-005 v_i  input  1  request valid.
REQ-006 ready_o  output  1  block can accept a request.
REQ-007 op_i  input  2  idiv_op_e: eDIV, eDIVU, eREM or eREMU.
REQ-008 dividend_i  input  width_p  rs1 value.
REQ-009 divisor_i  input  width_p  rs2 value.
REQ-010 tag_i  input  tag_width_p  destination tag.
REQ-011 flush_i  input  1  abort any in-flight operation.
REQ-012 v_o  output  1  result valid.
REQ-013 result_o  output  width_p  quotient for eDIV/eDIVU, remainder for eREM/eREMU.
REQ-014 tag_o  output  tag_width_p  tag captured with the request.
REQ-015 yumi_i  input  1  consumer takes the result; legal only while v_o=1.

Function
REQ-016 Request accepted on an edge where v_i & ready_o & ~flush_i; operands, op and tag registered on that edge.
REQ-017 ready_o SHALL be 1 only in IDLE; v_o SHALL be 1 only in DONE.
REQ-018 States: IDLE, PREP, CALC, FIX, DONE.
- IDLE->PREP on accept.
- PREP->DONE if special case, else CALC.
- CALC->FIX after exactly width_p iterations.
- FIX->DONE.
- DONE->IDLE on yumi_i.
REQ-019 PREP: for signed ops, take absolute values of the operands and record quotient and remainder sign; load iteration counter (width $clog2(width_p+1)) to width_p.
REQ-020 CALC: one restoring shift-subtract step per cycle on a width_p+1-bit partial remainder; counter decrements to 0.
REQ-021 FIX: for signed ops, negate the quotient when the operand signs differ; remainder takes the dividend's sign.
REQ-022 Normal latency: with accept at edge 0, v_o SHALL be 1 from cycle width_p+3 (35 for width_p=32) until yumi_i.
REQ-023 Divide-by-zero early-out, result at cycle 2:
- eDIV/eDIVU: all ones.
- eREM/eREMU: the dividend.
REQ-024 Signed overflow (dividend = most negative, divisor = -1, eDIV/eREM) early-out, result at cycle 2:
- eDIV: the dividend.
- eREM: 0.
REQ-025 result_o and tag_o SHALL hold stable while v_o=1 and yumi_i=0 (backpressure of unbounded length).
REQ-026 flush_i in PREP, CALC, FIX or DONE: next state IDLE, result discarded, v_o=0 next cycle.
REQ-027 flush_i in IDLE with v_i=1: request not accepted; flush wins.
REQ-028 yumi_i and flush_i together in DONE: next state IDLE, no difference in outcome.
REQ-029 No new request is accepted in the same cycle a result is consumed; next accept no earlier than the following cycle.

Reset
REQ-030 reset_i SHALL force state to IDLE, ready_o=1, v_o=0, result_o=0, tag_o=0, counter=0 on the next edge, regardless of state, and overrides v_i, yumi_i and flush_i.
REQ-031 Reset mid-operation SHALL drop the operation with no v_o pulse.

Structure
REQ-032 idiv_op_e stays in bsg_vanilla_pkg and is imported; no new package types.
REQ-033 The state enum is local to the module.
REQ-034 Single module, no sub-module; datapath is one width_p+1-bit subtractor shared by PREP negation, CALC and FIX.

Verification
REQ-035 width_p=32: eDIV dividend=0xFFFFFFF9 (-7), divisor=2 -> result_o=0xFFFFFFFD at cycle 35; eREM same operands -> 0xFFFFFFFF.
REQ-036 eDIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF at cycle 35; eREMU 100/7 -> 2; tag_i=5'h1A returned as tag_o=5'h1A.
REQ-037 eDIV 5/0 -> 0xFFFFFFFF at cycle 2; eREMU 5/0 -> 5 at cycle 2; eREM 0x80000000/0xFFFFFFFF -> 0 at cycle 2; eDIV same operands -> 0x80000000.
REQ-038 flush_i at cycle 10 of an eDIVU -> IDLE with ready_o=1 at cycle 11, no v_o; next request 81/9 -> 9.
REQ-039 yumi_i held 0 for 5 cycles after v_o -> result_o/tag_o constant, ready_o=0; yumi_i=1 -> ready_o=1 next cycle.
REQ-040 reset_i pulsed during CALC -> IDLE next cycle, v_o never asserts; width_p=8 rerun of REQ-035 scaled to 8-bit operands completes at cycle 11.
